pipelined_tree_adder: RTL

- Parametrised, pipelined successor to the combinational two-level tree adder: sums N_IN unsigned operands of WIDTH bits through a registered binary reduction tree.
- One pipeline register level per tree level; a valid bit travels alongside the data.
- Accepts one operand vector per clock and produces one full-precision sum per clock after a fixed latency.
- Sits in the datapath library as the reusable multi-operand adder for accumulation and checksum paths.

---
 rtl/pipelined_tree_adder.sv | 71 +++++++
 1 files changed

// File: rtl/pipelined_tree_adder.sv
// rtl/pipelined_tree_adder.sv - pipelined binary reduction tree summing N_IN operands, one level per cycle
// Optional build macro: PIPELINED_TREE_ADDER_SIGNED_EN (two's complement operands, sign-extending stages)
module pipelined_tree_adder #(
  parameter int N_IN  = 4,
  parameter int WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [N_IN*WIDTH-1:0]         in_data,
  output logic                          out_valid,
  output logic [WIDTH+$clog2(N_IN)-1:0] out_sum,
  output logic                          busy
);

  localparam int LOG2N = $clog2(N_IN);
  localparam int SUM_W = WIDTH + LOG2N;

  logic [LOG2N:1] v_all;

  for (genvar k = 1; k <= LOG2N; k++) begin : g_stage
    localparam int W   = WIDTH + k;
    localparam int CNT = N_IN >> k;

    logic [W-2:0] src [2*CNT];
    logic         src_v;
    logic [W-1:0] sum_r [CNT];
    logic         v_r;

    // Stage 0 is the raw input vector; later stages read the previous stage's registers
    if (k == 1) begin : g_first
      for (genvar j = 0; j < 2*CNT; j++) begin : g_src
        assign src[j] = in_data[j*WIDTH +: WIDTH];
      end
      assign src_v = in_valid;
    end else begin : g_next
      for (genvar j = 0; j < 2*CNT; j++) begin : g_src
        assign src[j] = g_stage[k-1].sum_r[j];
      end
      assign src_v = g_stage[k-1].v_r;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_r <= 1'b0;
        for (int j = 0; j < CNT; j++) begin
          sum_r[j] <= '0;
        end
      end else begin
        v_r <= src_v;
        // Hold through bubbles so the output keeps the last valid result
        if (src_v) begin
          for (int j = 0; j < CNT; j++) begin
`ifdef PIPELINED_TREE_ADDER_SIGNED_EN
            sum_r[j] <= {src[2*j][W-2], src[2*j]} + {src[2*j+1][W-2], src[2*j+1]};
`else
            sum_r[j] <= {1'b0, src[2*j]} + {1'b0, src[2*j+1]};
`endif
          end
        end
      end
    end

    assign v_all[k] = v_r;
  end

  assign out_valid = g_stage[LOG2N].v_r;
  assign out_sum   = g_stage[LOG2N].sum_r[0][SUM_W-1:0];
  assign busy      = |v_all;

endmodule
